// File: rtl/vram_wr_sched.sv
// VRAM write-port scheduler: merges converter pixel writes (always win) with a
// frame-clear sweep, counts pixels, swaps the double-buffer bank, aborts stalls.
module vram_wr_sched #(
    parameter int          ADDR_W     = 17,
    parameter int          DEPTH      = 76800,
    parameter logic [7:0]  CLR_VAL    = 8'h00,
    parameter int          TIMEOUT    = 1000000,
    parameter bit          AUTO_CLEAR = 1'b1
) (
    input  logic              dclk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rx_addr_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_we_r_i,
    input  logic              rx_we_g_i,
    input  logic              rx_we_b_i,
    input  logic              clr_start_i,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [7:0]        vram_din_o,
    output logic              vram_we_r_o,
    output logic              vram_we_g_o,
    output logic              vram_we_b_o,
    output logic              wr_bank_o,
    output logic              disp_bank_o,
    output logic              clr_busy_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic [ADDR_W-1:0] pix_count_o
);

    localparam int                IW      = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [IW-1:0]     TO_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0]     TO_MAX  = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RECV  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic [2:0]        we_q, we_d;
    logic              bank_q, bank_d;
    logic              disp_q, disp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic rx_wr;
    logic swap;
    logic tmo;

    assign rx_wr = rx_we_r_i | rx_we_g_i | rx_we_b_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pix_d   = pix_q;
        idle_d  = idle_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 3'b000;
        bank_d  = bank_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        swap    = 1'b0;
        tmo     = 1'b0;
        // busy follows the state one cycle late so it lines up with the
        // registered clear writes on the port
        busy_d  = (state_q == CLEAR);

        if (rx_wr) begin
            addr_d = rx_addr_i;
            din_d  = rx_data_i;
            we_d   = {rx_we_r_i, rx_we_g_i, rx_we_b_i};
        end

        // blue is the last plane of a pixel, so it marks completion
        if (rx_we_b_i) begin
            if (pix_q == LAST) begin
                swap   = 1'b1;
                pix_d  = '0;
                bank_d = ~bank_q;
                done_d = 1'b1;
            end else begin
                pix_d = pix_q + 1'b1;
            end
        end

        if (rx_wr) begin
            idle_d = '0;
        end else if (pix_q != '0) begin
            if (idle_q >= TO_LAST) begin
                idle_d = TO_MAX;
                tmo    = 1'b1;
                err_d  = 1'b1;
                pix_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (clr_start_i && (pix_q == '0)) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (rx_wr) begin
                    state_d = RECV;
                end
            end
            CLEAR: begin
                if (!rx_wr) begin
                    addr_d = ptr_q;
                    din_d  = CLR_VAL;
                    we_d   = 3'b111;
                    if (ptr_q == LAST) begin
                        ptr_d   = '0;
                        state_d = (pix_d != '0) ? RECV : IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            RECV: begin
                if (tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a frame swap overrides any pending clear request or sweep position
        if (swap) begin
            ptr_d   = '0;
            state_d = AUTO_CLEAR ? CLEAR : IDLE;
        end

        disp_d = ~bank_d;
    end

    always_ff @(posedge dclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pix_q   <= '0;
            idle_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 3'b000;
            bank_q  <= 1'b0;
            disp_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pix_q   <= pix_d;
            idle_q  <= idle_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            bank_q  <= bank_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign vram_addr_o  = addr_q;
    assign vram_din_o   = din_q;
    assign vram_we_r_o  = we_q[2];
    assign vram_we_g_o  = we_q[1];
    assign vram_we_b_o  = we_q[0];
    assign wr_bank_o    = bank_q;
    assign disp_bank_o  = disp_q;
    assign clr_busy_o   = busy_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
    assign pix_count_o  = pix_q;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Scoreboard bench for vram_wr_sched: expected port writes are queued by the
// stimulus and popped by a monitor whenever any vram_we is high.
module tb_vram_wr_sched;

    localparam int AW  = 17;
    localparam int DEP = 16;
    localparam int TO  = 20;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic [2:0]    we;
        logic          cb;
        logic          bank;
    } wr_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rx_addr;
    logic [7:0]    rx_data;
    logic          rx_we_r, rx_we_g, rx_we_b;
    logic          clr_start;

    logic [AW-1:0] vram_addr, pix_count;
    logic [7:0]    vram_din;
    logic          vram_we_r, vram_we_g, vram_we_b;
    logic          wr_bank, disp_bank, clr_busy, frame_done, frame_err;

    logic [AW-1:0] n_vram_addr, n_pix_count;
    logic [7:0]    n_vram_din;
    logic          n_vram_we_r, n_vram_we_g, n_vram_we_b;
    logic          n_wr_bank, n_disp_bank, n_clr_busy, n_frame_done, n_frame_err;

    wr_t exp_q[$];
    wr_t e;
    int  n_tests = 0;
    int  n_fail  = 0;

    vram_wr_sched #(.ADDR_W(AW), .DEPTH(DEP), .CLR_VAL(8'h00), .TIMEOUT(TO), .AUTO_CLEAR(1'b1)) dut (
        .dclk_i(clk), .rst_i(rst), .rx_addr_i(rx_addr), .rx_data_i(rx_data),
        .rx_we_r_i(rx_we_r), .rx_we_g_i(rx_we_g), .rx_we_b_i(rx_we_b), .clr_start_i(clr_start),
        .vram_addr_o(vram_addr), .vram_din_o(vram_din),
        .vram_we_r_o(vram_we_r), .vram_we_g_o(vram_we_g), .vram_we_b_o(vram_we_b),
        .wr_bank_o(wr_bank), .disp_bank_o(disp_bank), .clr_busy_o(clr_busy),
        .frame_done_o(frame_done), .frame_err_o(frame_err), .pix_count_o(pix_count)
    );

    vram_wr_sched #(.ADDR_W(AW), .DEPTH(DEP), .CLR_VAL(8'h00), .TIMEOUT(TO), .AUTO_CLEAR(1'b0)) dut_nc (
        .dclk_i(clk), .rst_i(rst), .rx_addr_i(rx_addr), .rx_data_i(rx_data),
        .rx_we_r_i(rx_we_r), .rx_we_g_i(rx_we_g), .rx_we_b_i(rx_we_b), .clr_start_i(clr_start),
        .vram_addr_o(n_vram_addr), .vram_din_o(n_vram_din),
        .vram_we_r_o(n_vram_we_r), .vram_we_g_o(n_vram_we_g), .vram_we_b_o(n_vram_we_b),
        .wr_bank_o(n_wr_bank), .disp_bank_o(n_disp_bank), .clr_busy_o(n_clr_busy),
        .frame_done_o(n_frame_done), .frame_err_o(n_frame_err), .pix_count_o(n_pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_addr"},  32'(vram_addr), 32'h0);
        chk({p, "_din"},   32'(vram_din), 32'h0);
        chk({p, "_we"},    32'({vram_we_r, vram_we_g, vram_we_b}), 32'h0);
        chk({p, "_bank"},  32'(wr_bank), 32'h0);
        chk({p, "_disp"},  32'(disp_bank), 32'h1);
        chk({p, "_busy"},  32'(clr_busy), 32'h0);
        chk({p, "_done"},  32'(frame_done), 32'h0);
        chk({p, "_err"},   32'(frame_err), 32'h0);
        chk({p, "_pix"},   32'(pix_count), 32'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rx_we_r   = 1'b0;
        rx_we_g   = 1'b0;
        rx_we_b   = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic push_clr(input int lo, input int hi, input logic bank);
        for (int a = lo; a <= hi; a++)
            exp_q.push_back('{addr: AW'(a), din: 8'h00, we: 3'b111, cb: 1'b1, bank: bank});
    endtask

    task automatic drive_rx(input int a, input logic [7:0] d, input logic [2:0] we);
        rx_addr = AW'(a);
        rx_data = d;
        {rx_we_r, rx_we_g, rx_we_b} = we;
        exp_q.push_back('{addr: AW'(a), din: d, we: we, cb: 1'b0, bank: 1'b0});
    endtask

    // Monitor: every port write must match the head of the expected queue
    always @(negedge clk) begin
        if (vram_we_r | vram_we_g | vram_we_b) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h din %0h we %b, want no write",
                         vram_addr, vram_din, {vram_we_r, vram_we_g, vram_we_b});
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(vram_addr), 32'(e.addr));
                chk("wr_din",  32'(vram_din), 32'(e.din));
                chk("wr_we",   32'({vram_we_r, vram_we_g, vram_we_b}), 32'(e.we));
                if (e.cb) chk("wr_bank", 32'(wr_bank), 32'(e.bank));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy;
        int at;
        rst = 1'b1;
        rx_addr = '0;
        rx_data = '0;
        idle_in();
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");
        cyc();

        // Plain clear sweep
        push_clr(0, DEP - 1, 1'b0);
        busy = 0;
        for (int k = 0; k < 24; k++) begin
            clr_start = (k == 0);
            @(negedge clk);
            if (clr_busy) busy++;
            if (k == 1) chk("clr_busy_lag", 32'(clr_busy), 32'h0);
            if (k == 2) chk("clr_busy_rise", 32'(clr_busy), 32'h1);
            cyc();
        end
        clr_start = 1'b0;
        chk("clr_busy_cycles", 32'(busy), 32'd16);
        chk("clr_q_empty", 32'(exp_q.size()), 32'd0);
        chk("clr_bank", 32'(wr_bank), 32'h0);

        // Clear paused by RX write at pointer 3; second clr_start ignored
        push_clr(0, 2, 1'b0);
        exp_q.push_back('{addr: AW'(5), din: 8'hAA, we: 3'b100, cb: 1'b0, bank: 1'b0});
        push_clr(3, DEP - 1, 1'b0);
        busy = 0;
        for (int k = 0; k < 30; k++) begin
            clr_start = (k == 0 || k == 6);
            rx_addr   = AW'(5);
            rx_data   = 8'hAA;
            rx_we_r   = (k == 4);
            @(negedge clk);
            if (clr_busy) busy++;
            cyc();
        end
        idle_in();
        chk("pause_busy_cycles", 32'(busy), 32'd17);
        chk("pause_q_empty", 32'(exp_q.size()), 32'd0);

        // Full frame R,G,B per pixel, data = addr; auto-clear follows
        for (int p = 0; p < DEP; p++) begin
            for (int c = 0; c < 3; c++) begin
                drive_rx(p, 8'(p), 3'b100 >> c);
                if (p == DEP - 1 && c == 2) push_clr(0, DEP - 1, 1'b1);
                @(negedge clk);
                if (p == DEP - 1 && c == 2) begin
                    chk("pix_before_last", 32'(pix_count), 32'd15);
                    chk("done_before_last", 32'(frame_done), 32'h0);
                end
                cyc();
            end
        end
        idle_in();
        @(negedge clk);
        chk("swap_done", 32'(frame_done), 32'h1);
        chk("swap_bank", 32'(wr_bank), 32'h1);
        chk("swap_disp", 32'(disp_bank), 32'h0);
        chk("swap_pix", 32'(pix_count), 32'h0);
        chk("swap_busy", 32'(clr_busy), 32'h0);
        chk("nc_swap_done", 32'(n_frame_done), 32'h1);
        cyc();
        @(negedge clk);
        chk("done_pulse_end", 32'(frame_done), 32'h0);
        chk("autoclr_busy", 32'(clr_busy), 32'h1);
        chk("nc_no_autoclr", 32'(n_clr_busy), 32'h0);
        chk("nc_bank", 32'(n_wr_bank), 32'h1);
        cyc();
        repeat (18) cyc();
        @(negedge clk);
        chk("autoclr_done", 32'(clr_busy), 32'h0);
        chk("autoclr_q_empty", 32'(exp_q.size()), 32'd0);
        cyc();

        // Timeout: 5 pixels then silence; clr_start mid-frame ignored
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 3; c++) begin
                drive_rx(p, 8'(8'h40 + p), 3'b100 >> c);
                cyc();
            end
        idle_in();
        at = -1;
        busy = 0;
        for (int k = 0; k < 40 && at < 0; k++) begin
            clr_start = (k == 1);
            @(negedge clk);
            if (k == 0) chk("tmo_pix5", 32'(pix_count), 32'd5);
            if (clr_busy) busy++;
            if (frame_err) begin
                at = k;
                chk("tmo_pix", 32'(pix_count), 32'h0);
                chk("tmo_bank", 32'(wr_bank), 32'h1);
                chk("tmo_no_done", 32'(frame_done), 32'h0);
            end
            cyc();
        end
        clr_start = 1'b0;
        chk("tmo_latency", 32'(at), 32'd20);
        chk("tmo_clr_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_pulse_end", 32'(frame_err), 32'h0);
        chk("tmo_q_empty", 32'(exp_q.size()), 32'd0);
        cyc();

        // Reset mid-sweep at pointer 7
        push_clr(0, 6, 1'b1);
        busy = 0;
        for (int k = 0; k < 30; k++) begin
            clr_start = (k == 0);
            rst       = (k == 8);
            @(negedge clk);
            if (k == 8) chk("pre_rst_busy", 32'(clr_busy), 32'h1);
            if (k == 9) chk_reset("mid_rst");
            if (k > 9 && clr_busy) busy++;
            cyc();
        end
        idle_in();
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("rst_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_wr_sched.md
Name: vram_wr_sched

Overview:
- Owns the three-plane (R/G/B) VRAM write port behind the byte-to-RGB converter of the Ethernet RX path.
- Merges two requesters onto that port: converter pixel writes, which have absolute priority and no backpressure, and an internal frame-clear sweep.
- Counts completed pixels and swaps a double-buffer bank at end of frame.
- Aborts stalled frames on timeout.

Parameters:
- ADDR_W, 17, VRAM word address width per plane.
- DEPTH, 76800, pixels per frame (320x240). Last address is DEPTH-1.
- CLR_VAL, 8'h00, byte written to all planes during clear.
- TIMEOUT, 1000000, idle dclk cycles mid-frame before abort.
- AUTO_CLEAR, 1, when 1 a clear of the new write bank starts automatically after each frame swap.

Ports:
- dclk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_addr  in  ADDR_W  converter pixel address.
- rx_data  in  8  converter byte.
- rx_we_r / rx_we_g / rx_we_b  in  1 each  converter plane strobes; at most one high per cycle.
- clr_start  in  1  pulse: request clear of the write bank.
- vram_addr  out  ADDR_W  write address.
- vram_din  out  8  write data.
- vram_we_r / vram_we_g / vram_we_b  out  1 each  plane write enables.
- wr_bank  out  1  bank currently written; VRAM MSB.
- disp_bank  out  1  bank for scan-out; always ~wr_bank.
- clr_busy  out  1  clear sweep in progress.
- frame_done  out  1  one-cycle pulse on frame swap.
- frame_err  out  1  one-cycle pulse on timeout abort.
- pix_count  out  ADDR_W  pixels completed in the current frame.

Behaviour:
- Reset values:
  - vram_addr=0, vram_din=0, all vram_we*=0.
  - wr_bank=0, disp_bank=1.
  - clr_busy=0, frame_done=0, frame_err=0, pix_count=0.
  - State IDLE, clear pointer 0, idle counter 0.
  - rst mid-sweep or mid-frame aborts immediately, with no pulses.
- All outputs are registered. A port write appears exactly 1 cycle after its source request.
- An RX write is any rx_we_* high. It is forwarded unchanged (addr, data, strobe) in every state and always wins the port.
- States:
  - IDLE:
    - clr_start while pix_count==0 -> CLEAR, pointer=0.
    - clr_start while pix_count!=0 is ignored.
    - Any RX write -> RECV.
  - CLEAR:
    - In each cycle without an RX write: drive addr=pointer, din=CLR_VAL, all three vram_we*=1, then pointer++.
    - In cycles with an RX write: pointer holds and the clear pauses.
    - After issuing address DEPTH-1: pointer=0, clr_busy=0, go to IDLE (or RECV if pix_count!=0).
    - clr_busy=1 throughout CLEAR, including paused cycles.
    - RX writes during CLEAR are counted as normal.
  - RECV:
    - Each cycle with rx_we_b=1 completes one pixel.
    - If pix_count==DEPTH-1 on that cycle: pix_count=0, wr_bank toggles, frame_done=1 for one cycle.
      - If AUTO_CLEAR=1: enter CLEAR with pointer=0 in the cycle after the swap. Clear writes target the new wr_bank.
      - Otherwise go to IDLE.
    - Otherwise pix_count++.
- Timeout:
  - The idle counter increments on cycles with no RX write while pix_count!=0, and clears on any RX write.
  - On reaching TIMEOUT: frame_err=1 for one cycle, pix_count=0, no bank swap, go to IDLE.
  - The idle counter does not run while pix_count==0.
- Simultaneous events:
  - Completing blue write and clr_start in the same cycle: the swap takes priority and clr_start is dropped. AUTO_CLEAR still applies.
  - clr_start while already in CLEAR is ignored; the pointer is not restarted.
  - Timeout and RX write in the same cycle: the RX write wins and the counter clears.
- Width rules:
  - Pointer and pix_count are ADDR_W bits and never exceed DEPTH-1.
  - The idle counter is clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
- Known limitation: RX writes landing during CLEAR at addresses above the pointer are later overwritten by the sweep. Senders start frames after clr_busy falls.

Test Plan:
- Reset, then DEPTH=16, clr_start with no RX -> 16 consecutive cycles of all three vram_we*=1, vram_addr 0..15, din=00. clr_busy high for 16 cycles. wr_bank=0.
- DEPTH=16, AUTO_CLEAR=0, 48 strobes R,G,B cycling, addr 0..15, data=addr -> writes echoed 1 cycle later. pix_count reaches 15. On the 16th blue: frame_done pulse, wr_bank=1, disp_bank=0, pix_count=0.
- Clear running, RX R write addr 5 data AA injected at pointer 3 -> cycle shows only vram_we_r, addr 5, AA. Next clear write is addr 3. Sweep totals 16 clear writes.
- TIMEOUT=20, 5 pixels then silence -> frame_err pulses exactly 20 cycles after the last write. pix_count=0, wr_bank unchanged.
- AUTO_CLEAR=1, frame completes -> frame_done, then clr_busy rises the next cycle. Clear writes appear with wr_bank=1.
- Assert rst at pointer 7 mid-clear -> next cycle all outputs at reset values. No further VRAM writes.
